// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the PC and the instruction-memory handshake,
// and turns control_unit strobes into phased register-file and data-memory enables.
module instr_sequencer #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [5:0]      opcode,
    output logic [8:0]      xoxo,
    output logic [9:0]      xox,
    output logic [1:0]      xods,
    input  logic            ctl_regread,
    input  logic            ctl_regwrite,
    input  logic            ctl_memread,
    input  logic            ctl_memwrite,
    input  logic            ctl_branch,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            rf_rd_en,
    output logic            rf_wr_en,
    output logic            dmem_rd_en,
    output logic            dmem_wr_en,
    input  logic            dmem_ready,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic            halted
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CTL_W   = 5;
    localparam int unsigned CTL_RR  = 4;
    localparam int unsigned CTL_RW  = 3;
    localparam int unsigned CTL_MR  = 2;
    localparam int unsigned CTL_MW  = 1;
    localparam int unsigned CTL_BR  = 0;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [CTL_W-1:0]   r_ctl_q;
    logic [CTL_W-1:0]   w_ctl;

    assign w_ctl = {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch};

    // Sequencer state, PC, IR and latched control strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ctl_q <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ctl_q <= w_ctl;
                    if (w_ctl == '0) begin
                        r_state <= S_HALT;
                    end else if (ctl_regread) begin
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_READ: begin
                    r_state <= (r_ctl_q[CTL_MR] || r_ctl_q[CTL_MW]) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    // Taken branches land on a word-aligned target; otherwise step, wrapping at 2^PC_W
                    if (r_ctl_q[CTL_BR] && branch_taken) begin
                        r_pc <= branch_target & ALIGN_MASK;
                    end else begin
                        r_pc <= r_pc + PC_STEP;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Moore-decoded enables, held low for as long as reset is asserted
    assign imem_req   = rst_n && (r_state == S_FETCH);
    assign rf_rd_en   = rst_n && (r_state == S_READ);
    assign rf_wr_en   = rst_n && (r_state == S_WB)  && r_ctl_q[CTL_RW];
    assign dmem_rd_en = rst_n && (r_state == S_MEM) && r_ctl_q[CTL_MR];
    assign dmem_wr_en = rst_n && (r_state == S_MEM) && r_ctl_q[CTL_MW];
    assign halted     = (r_state == S_HALT);

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;

    assign opcode = r_ir[31:26];
    assign xoxo   = r_ir[9:1];
    assign xox    = r_ir[10:1];
    assign xods   = r_ir[1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer; a per-instruction cycle model
// predicts the enable pattern, fields and next PC from the instruction's class and wait counts.
module tb_instr_sequencer;

    localparam int unsigned     PC_W     = 64;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic [5:0]      opcode;
    logic [8:0]      xoxo;
    logic [9:0]      xox;
    logic [1:0]      xods;
    logic            ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en;
    logic            dmem_ready;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic            halted;

    int tests;
    int fails;
    logic [PC_W-1:0] model_pc;

    instr_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .opcode(opcode), .xoxo(xoxo), .xox(xox), .xods(xods),
        .ctl_regread(ctl_regread), .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread),
        .ctl_memwrite(ctl_memwrite), .ctl_branch(ctl_branch),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .rf_rd_en(rf_rd_en), .rf_wr_en(rf_wr_en), .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en),
        .dmem_ready(dmem_ready), .pc(pc), .ir(ir), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scramble every non-reset input; used where the DUT must ignore them
    task automatic scramble_inputs();
        imem_ready    = 1'($urandom);
        imem_rdata    = $urandom;
        {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch} = 5'($urandom);
        branch_taken  = 1'($urandom);
        branch_target = {$urandom, $urandom};
        dmem_ready    = 1'($urandom);
    endtask

    // Executes one instruction; ctl = {regread, regwrite, memread, memwrite, branch}
    task automatic run_instr(input logic [31:0] instr, input logic [4:0] ctl, input int iw,
                             input int dw, input logic taken, input logic [63:0] target);
        int n_fetch, n_read, n_mem, mem_start, wb_idx, n_total;
        logic illegal;
        logic [4:0] exp_en, act_en;
        logic [PC_W-1:0] next_pc;
        logic [26:0] exp_fields;
        illegal    = (ctl == 5'b0);
        n_fetch    = iw + 1;
        n_read     = (!illegal && ctl[4]) ? 1 : 0;
        n_mem      = (n_read == 1 && (ctl[2] || ctl[1])) ? dw + 1 : 0;
        mem_start  = n_fetch + 1 + n_read;
        wb_idx     = mem_start + n_mem;
        n_total    = illegal ? n_fetch + 1 : wb_idx + 1;
        next_pc    = (ctl[0] && taken) ? (target & ~64'h3) : model_pc + 64'd4;
        exp_fields = {instr[31:26], instr[9:1], instr[10:1], instr[1:0]};
        for (int c = 0; c < n_total; c++) begin
            @(negedge clk);
            scramble_inputs();
            if (c < n_fetch) begin
                imem_ready = (c == n_fetch - 1);
                imem_rdata = instr;
            end
            if (c == n_fetch)
                {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch} = ctl;
            if (c >= mem_start && c < wb_idx)
                dmem_ready = (c == wb_idx - 1);
            if (!illegal && c == wb_idx) begin
                branch_taken  = taken;
                branch_target = target;
            end
            #1;
            exp_en = '0;
            if (c < n_fetch)                                  exp_en[4] = 1'b1;
            else if (!illegal && n_read == 1 && c == n_fetch + 1) exp_en[3] = 1'b1;
            else if (!illegal && c >= mem_start && c < wb_idx) exp_en[1:0] = ctl[2:1];
            else if (!illegal && c == wb_idx)                 exp_en[2] = ctl[3];
            act_en = {imem_req, rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en};
            tests++;
            if (act_en !== exp_en) begin
                fails++;
                $display("FAIL enables instr=%h cyc=%0d {req,rd,wr,drd,dwr}: got %b want %b", instr, c, act_en, exp_en);
            end
            tests++;
            if (pc !== model_pc || imem_addr !== model_pc) begin
                fails++;
                $display("FAIL pc instr=%h cyc=%0d: pc=%h addr=%h want %h", instr, c, pc, imem_addr, model_pc);
            end
            if (c >= n_fetch) begin
                tests++;
                if (ir !== instr || {opcode, xoxo, xox, xods} !== exp_fields) begin
                    fails++;
                    $display("FAIL fields instr=%h cyc=%0d: ir=%h fields=%h want %h", instr, c, ir, {opcode, xoxo, xox, xods}, exp_fields);
                end
            end
            tests++;
            if (halted !== 1'b0) begin
                fails++;
                $display("FAIL halted_early instr=%h cyc=%0d: got %b want 0", instr, c, halted);
            end
        end
        if (!illegal) model_pc = next_pc;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            scramble_inputs();
            rst_n = 1'b0;
            #1;
            tests++;
            if ({imem_req, rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en} !== 5'b0) begin
                fails++;
                $display("FAIL reset_enables: got %b want 00000", {imem_req, rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b0;
        #1;
        tests++;
        if (pc !== RESET_PC || ir !== 32'h0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            fails++;
            $display("FAIL reset_state: pc=%h ir=%h halted=%b req=%b addr=%h", pc, ir, halted, imem_req, imem_addr);
        end
        model_pc = RESET_PC;
    endtask

    task automatic test_addi();
        run_instr(32'h38610005, 5'b11000, 0, 0, 1'b0, 64'h0);
        tests++;
        if (opcode !== 6'd14) begin
            fails++;
            $display("FAIL addi_opcode: got %0d want 14", opcode);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd4) begin
            fails++;
            $display("FAIL addi_next_addr: req=%b addr=%h want 1/4", imem_req, imem_addr);
        end
    endtask

    task automatic test_add();
        run_instr(32'h7C611214, 5'b11000, 1, 0, 1'b0, 64'h0);
        tests++;
        if (opcode !== 6'd31 || xoxo !== 9'd266) begin
            fails++;
            $display("FAIL add_fields: opcode=%0d xoxo=%0d want 31/266", opcode, xoxo);
        end
    endtask

    task automatic test_ld_wait();
        run_instr(32'hE8810008, 5'b11100, 0, 3, 1'b0, 64'h0);
        tests++;
        if (opcode !== 6'd58 || xods !== 2'd0) begin
            fails++;
            $display("FAIL ld_fields: opcode=%0d xods=%0d want 58/0", opcode, xods);
        end
    endtask

    task automatic test_branch();
        run_instr(32'h48000010, 5'b00001, 0, 0, 1'b1, 64'h13);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        tests++;
        if (pc !== 64'h10) begin
            fails++;
            $display("FAIL branch_pc: got %h want 10", pc);
        end
    endtask

    task automatic test_wrap();
        run_instr(32'h48000000, 5'b00001, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(32'h38610005, 5'b11000, 0, 0, 1'b0, 64'h0);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        tests++;
        if (pc !== 64'h0 || imem_addr !== 64'h0) begin
            fails++;
            $display("FAIL wrap_pc: pc=%h addr=%h want 0", pc, imem_addr);
        end
    endtask

    task automatic test_halt();
        run_instr(32'h00000000, 5'b00000, 1, 0, 1'b0, 64'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            scramble_inputs();
            #1;
            tests++;
            if (halted !== 1'b1 || {imem_req, rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en} !== 5'b0) begin
                fails++;
                $display("FAIL halt_hold cyc=%0d: halted=%b en=%b want 1/00000", i, halted,
                         {imem_req, rf_rd_en, rf_wr_en, dmem_rd_en, dmem_wr_en});
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b0;
        #1;
        tests++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            fails++;
            $display("FAIL halt_clear: halted=%b req=%b addr=%h", halted, imem_req, imem_addr);
        end
        model_pc = RESET_PC;
    endtask

    task automatic test_reset_abort();
        // Store held in MEM by dmem_ready low, then reset
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            scramble_inputs();
            dmem_ready = 1'b0;
            if (c == 0) begin imem_ready = 1'b1; imem_rdata = 32'hF8810008; end
            if (c == 1) {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch} = 5'b10010;
            if (c == 4) rst_n = 1'b0;
            if (c == 5) begin rst_n = 1'b1; imem_ready = 1'b0; end
            #1;
            if (c == 3) begin
                tests++;
                if (dmem_wr_en !== 1'b1 || dmem_rd_en !== 1'b0) begin
                    fails++;
                    $display("FAIL store_mem: wr=%b rd=%b want 1/0", dmem_wr_en, dmem_rd_en);
                end
            end
            if (c == 4) begin
                tests++;
                if (dmem_wr_en !== 1'b0 || rf_wr_en !== 1'b0 || imem_req !== 1'b0) begin
                    fails++;
                    $display("FAIL store_abort: dwr=%b rfwr=%b req=%b want 0", dmem_wr_en, rf_wr_en, imem_req);
                end
            end
            if (c == 5) begin
                tests++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                    fails++;
                    $display("FAIL store_refetch: req=%b addr=%h", imem_req, imem_addr);
                end
            end
        end
        // addi aborted in its WB cycle: no writeback, PC stays at RESET_PC
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            scramble_inputs();
            if (c == 0) begin imem_ready = 1'b1; imem_rdata = 32'h38610005; end
            if (c == 1) {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch} = 5'b11000;
            if (c == 3) rst_n = 1'b0;
            if (c == 4) begin rst_n = 1'b1; imem_ready = 1'b0; end
            #1;
            if (c == 3) begin
                tests++;
                if (rf_wr_en !== 1'b0) begin
                    fails++;
                    $display("FAIL wb_abort_wr: got %b want 0", rf_wr_en);
                end
            end
            if (c == 4) begin
                tests++;
                if (pc !== RESET_PC || imem_req !== 1'b1) begin
                    fails++;
                    $display("FAIL wb_abort_pc: pc=%h req=%b want %h/1", pc, imem_req, RESET_PC);
                end
            end
        end
        model_pc = RESET_PC;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr;
        logic [4:0]  ctl;
        logic        taken;
        logic [63:0] target;
        for (int n = 0; n < 40; n++) begin
            taken  = 1'b0;
            target = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: begin instr = {6'd14, 26'($urandom)}; ctl = 5'b11000; end
                1: begin instr = {6'd58, 26'($urandom)}; ctl = 5'b11100; end
                2: begin instr = {6'd62, 26'($urandom)}; ctl = 5'b10010; end
                3: begin instr = {6'd18, 26'($urandom)}; ctl = 5'b00001; taken = 1'b1; end
                4: begin instr = {6'd16, 26'($urandom)}; ctl = 5'b10001; taken = 1'($urandom); end
                default: begin instr = {6'd31, 26'($urandom)}; ctl = 5'b01000; end
            endcase
            run_instr(instr, ctl, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), taken, target);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_pc = RESET_PC;
        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        {ctl_regread, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch} = '0;
        branch_taken = 1'b0;
        branch_target = '0;
        dmem_ready = 1'b0;
        test_reset();
        test_addi();
        test_add();
        test_ld_wait();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the uPOWER core. It fetches a 32-bit instruction and splits it into the opcode/xoxo/xox/xods fields consumed by `control_unit`. It samples the returned RegRead/RegWrite/MemRead/MemWrite/Branch strobes and turns them into phased enables for the register file and data memory. It owns the program counter and the instruction-memory handshake.

## Interface
- `PC_W`, default 64: program counter / address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address (= pc).
- `imem_ready`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `opcode`  out  6  ir[31:26], to control_unit.
- `xoxo`  out  9  ir[9:1] (XO-form extended opcode).
- `xox`  out  10  ir[10:1] (X-form extended opcode).
- `xods`  out  2  ir[1:0] (DS-form sub-opcode).
- `ctl_regread`, `ctl_regwrite`, `ctl_memread`, `ctl_memwrite`, `ctl_branch`  in  1 each  strobes from control_unit.
- `branch_taken`  in  1  branch condition result from datapath (driven 1 for unconditional branches).
- `branch_target`  in  PC_W  computed target.
- `rf_rd_en`  out  1  register-file read phase.
- `rf_wr_en`  out  1  register-file writeback strobe.
- `dmem_rd_en`, `dmem_wr_en`  out  1 each  data-memory access.
- `dmem_ready`  in  1  data access complete.
- `pc`  out  PC_W  current PC.
- `ir`  out  32  instruction register.
- `halted`  out  1  sticky illegal-instruction halt.

## Operation
- States: FETCH, DECODE, READ, MEM, WB, HALT. All outputs are Moore-decoded from state plus registered values.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On imem_ready: ir<=imem_rdata, go to DECODE.
  - imem_ready outside FETCH is ignored.
- DECODE:
  - Field outputs derive combinationally from ir and stay stable from DECODE through WB.
  - Register the five ctl_* strobes into ctl_q.
  - No strobe set: go to HALT.
  - Otherwise, if ctl_regread: go to READ, else go to WB.
- READ: rf_rd_en=1 for exactly one cycle. Then MEM if memread|memwrite, else WB.
- MEM:
  - dmem_rd_en=ctl_q.memread and dmem_wr_en=ctl_q.memwrite, both held until dmem_ready.
  - On dmem_ready: go to WB.
- WB:
  - rf_wr_en=ctl_q.regwrite for one cycle.
  - If ctl_q.branch & branch_taken: pc<={branch_target[PC_W-1:2],2'b00}. Otherwise pc<=pc+4, modulo 2^PC_W (wraps to 0).
  - Go to FETCH.
- HALT: halted=1. All enables and imem_req stay 0 until reset.
- At most one of rf_rd_en, rf_wr_en, dmem_rd_en/dmem_wr_en, imem_req is active in any cycle.

## Timing
- Reset (rst_n low at edge):
  - state=FETCH, pc=RESET_PC, ir=0, ctl_q=0, halted=0.
  - While rst_n low, every enable and imem_req is forced 0.
  - The first imem_req comes in the first cycle rst_n is high.
- Reset mid-MEM or mid-WB aborts the instruction: no rf_wr_en and no pc update that cycle.
- Zero-wait latency (imem_ready and dmem_ready high on first request), FETCH to next FETCH:
  - ALU (addi/add): 4 cycles (FETCH, DECODE, READ, WB).
  - Load/store: 5 cycles.
  - Unconditional branch: 3 cycles (FETCH, DECODE, WB).
- Each wait cycle on imem_ready or dmem_ready adds one cycle.
- Conditional branch must have branch_taken/branch_target valid in the WB cycle.
- ctl_* strobes are sampled only in DECODE. Changes in other states have no effect.

## Test plan
- addi r3,r1,5 (0x38610005) at pc=0, zero-wait -> opcode=14, rf_rd_en in cycle 3, rf_wr_en in cycle 4, next imem_addr=4.
- add r3,r1,r2 (0x7C611214) -> opcode=31, xoxo=266, 4-cycle sequence, no dmem enables.
- ld r4,8(r1) (0xE8810008) with dmem_ready delayed 3 cycles -> opcode=58, xods=0; dmem_rd_en high 4 cycles, then one rf_wr_en; total 8 cycles.
- b +16 (0x48000010), branch_taken=1, target=0x13 -> no rf_rd_en/rf_wr_en; pc becomes 0x10 after 3 cycles.
- Instruction 0x00000000 -> halted=1 the cycle after DECODE. No further imem_req over 20 cycles. rst_n low one edge clears halted and refetches from RESET_PC.
- pc=2^64-4 executing addi -> pc wraps to 0. Reset asserted during MEM of a store -> dmem_wr_en drops, no rf_wr_en, and imem_addr=RESET_PC once reset releases.
